// File: rtl/rf_pkg.sv
// Shared constants, the per-port read status bundle and the popcount helper
// used by the multi-port register file and its busy scoreboard.
package rf_pkg;

  localparam int RF_DATA_W = 32;
  localparam int RF_ADDR_W = 5;

  // Register index that is hardwired to zero when ZERO_REG is enabled.
  localparam int REG_ZERO = 0;

  // Largest depth the popcount helper covers (ADDR_W up to 8).
  localparam int RF_MAX_DEPTH = 256;

  // Per-read-port status: read valid, same-cycle write hit, resolved busy.
  typedef struct packed {
    logic en;
    logic wr_hit;
    logic busy;
  } rd_port_t;

  // Number of set bits in a busy vector (zero-extended to RF_MAX_DEPTH).
  function automatic logic [15:0] popcount(input logic [RF_MAX_DEPTH-1:0] v);
    logic [15:0] n;
    n = '0;
    for (int i = 0; i < RF_MAX_DEPTH; i++) begin
      n = n + 16'(v[i]);
    end
    return n;
  endfunction

endpackage

// File: rtl/rf_scoreboard.sv
// Per-register busy bits for long-latency producers. A write-back clears the
// bit of its destination, an issue sets it; when both hit the same register
// in one cycle the set wins because a newer producer owns the result.
module rf_scoreboard
  import rf_pkg::*;
#(
  parameter int ADDR_W   = RF_ADDR_W,
  parameter int ZERO_REG = 1
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   clr_en,
  input  logic [ADDR_W-1:0]      clr_addr,
  input  logic                   set_en,
  input  logic [ADDR_W-1:0]      set_addr,
  output logic [(1<<ADDR_W)-1:0] busy,
  output logic [ADDR_W:0]        busy_cnt
);

  localparam int DEPTH = 1 << ADDR_W;

  logic [DEPTH-1:0] busy_nxt;

  // Next-state busy vector: clear first, then set, register zero never busy.
  always_comb begin
    busy_nxt = busy;
    if (clr_en) busy_nxt[clr_addr] = 1'b0;
    if (set_en) busy_nxt[set_addr] = 1'b1;
    if (ZERO_REG != 0) busy_nxt[REG_ZERO] = 1'b0;
  end

  // Busy bits and their count update together so the count matches the bits.
  always_ff @(posedge clk) begin
    if (reset) begin
      busy     <= '0;
      busy_cnt <= '0;
    end else begin
      busy     <= busy_nxt;
      busy_cnt <= (ADDR_W+1)'(popcount(RF_MAX_DEPTH'(busy_nxt)));
    end
  end

endmodule

// File: rtl/regfile_mp_sb.sv
// Multi-port CPU register file with write-to-read bypass, a busy scoreboard
// for long-latency producers and a registered hazard stall. Reads are
// combinational; the single write port comes from WB, scoreboard sets from
// issue logic.
module regfile_mp_sb
  import rf_pkg::*;
#(
  parameter int DATA_W   = RF_DATA_W,
  parameter int ADDR_W   = RF_ADDR_W,
  parameter int NUM_RD   = 2,
  parameter int BYPASS   = 1,
  parameter int ZERO_REG = 1
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [NUM_RD-1:0]        rd_en,
  input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
  output logic [NUM_RD*DATA_W-1:0] rd_data,
  output logic [NUM_RD-1:0]        rd_busy,
  input  logic                     we,
  input  logic [ADDR_W-1:0]        wa,
  input  logic [DATA_W-1:0]        wd,
  input  logic                     sb_set,
  input  logic [ADDR_W-1:0]        sb_addr,
  output logic                     stall,
  output logic [ADDR_W:0]          busy_cnt
);

  localparam int DEPTH = 1 << ADDR_W;
  localparam logic [ADDR_W-1:0] ZERO_ADDR = ADDR_W'(REG_ZERO);
  localparam logic ZR = (ZERO_REG != 0);
  localparam logic BP = (BYPASS != 0);

  if (NUM_RD < 1 || NUM_RD > 4) begin : g_bad_num_rd
    $error("regfile_mp_sb: NUM_RD must be in 1..4");
  end
  if (DEPTH > RF_MAX_DEPTH) begin : g_bad_addr_w
    $error("regfile_mp_sb: ADDR_W too large for the busy counter");
  end

  logic [DATA_W-1:0] mem [DEPTH];
  logic [DEPTH-1:0]  busy;
  logic [NUM_RD-1:0] port_hz;
  logic              wr_ok;

  // A write to the hardwired zero register is dropped everywhere.
  assign wr_ok = we & ~(ZR & (wa == ZERO_ADDR));

  // Storage array: reset clears every entry, otherwise a single write port.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (wr_ok) begin
      mem[wa] <= wd;
    end
  end

  rf_scoreboard #(
    .ADDR_W   (ADDR_W),
    .ZERO_REG (ZERO_REG)
  ) u_sb (
    .clk      (clk),
    .reset    (reset),
    .clr_en   (we),
    .clr_addr (wa),
    .set_en   (sb_set),
    .set_addr (sb_addr),
    .busy     (busy),
    .busy_cnt (busy_cnt)
  );

  for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
    logic [ADDR_W-1:0] a;
    logic [DATA_W-1:0] data_k;
    rd_port_t          st;

    assign a = rd_addr[k*ADDR_W +: ADDR_W];

    // Zero register first, then bypass of the in-flight write, then storage;
    // a write to the read address also resolves that register's busy bit.
    always_comb begin
      st.en     = rd_en[k];
      st.wr_hit = BP & wr_ok & (wa == a);
      st.busy   = busy[a] & ~(BP & we & (wa == a));
      if (ZR && a == ZERO_ADDR) data_k = '0;
      else if (st.wr_hit)       data_k = wd;
      else                      data_k = mem[a];
    end

    assign rd_data[k*DATA_W +: DATA_W] = data_k;
    assign rd_busy[k]                  = st.busy;
    assign port_hz[k]                  = st.en & st.busy;
  end

  // Hazard flag registered for the next cycle; only valid reads can stall.
  always_ff @(posedge clk) begin
    if (reset) stall <= 1'b0;
    else       stall <= |port_hz;
  end

endmodule

// File: tb/tb_regfile_mp_sb.sv
// Directed bench for regfile_mp_sb in its default configuration
// (32x32, two read ports, bypass on, register zero hardwired).
module tb_regfile_mp_sb;

  localparam int DATA_W = 32;
  localparam int ADDR_W = 5;
  localparam int NUM_RD = 2;

  logic                     clk = 1'b0;
  logic                     reset = 1'b1;
  logic [NUM_RD-1:0]        rd_en = '0;
  logic [NUM_RD*ADDR_W-1:0] rd_addr = '0;
  logic [NUM_RD*DATA_W-1:0] rd_data;
  logic [NUM_RD-1:0]        rd_busy;
  logic                     we = 1'b0;
  logic [ADDR_W-1:0]        wa = '0;
  logic [DATA_W-1:0]        wd = '0;
  logic                     sb_set = 1'b0;
  logic [ADDR_W-1:0]        sb_addr = '0;
  logic                     stall;
  logic [ADDR_W:0]          busy_cnt;

  int checks = 0;
  int failures = 0;
  logic [DATA_W-1:0] exp_q[$];

  regfile_mp_sb #(
    .DATA_W   (DATA_W),
    .ADDR_W   (ADDR_W),
    .NUM_RD   (NUM_RD),
    .BYPASS   (1),
    .ZERO_REG (1)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .rd_en    (rd_en),
    .rd_addr  (rd_addr),
    .rd_data  (rd_data),
    .rd_busy  (rd_busy),
    .we       (we),
    .wa       (wa),
    .wd       (wd),
    .sb_set   (sb_set),
    .sb_addr  (sb_addr),
    .stall    (stall),
    .busy_cnt (busy_cnt)
  );

  // Clock
  always #5 clk = ~clk;

  // Driver helpers: inputs change 1 time unit after the rising edge,
  // combinational outputs are checked 1 unit after that.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_reads(input logic [1:0] en, input logic [ADDR_W-1:0] a0,
                           input logic [ADDR_W-1:0] a1);
    rd_en   = en;
    rd_addr = {a1, a0};
  endtask

  task automatic idle();
    we = 1'b0;
    sb_set = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    set_reads(2'b11, 5'd5, 5'd9);
    #1;
    checks++;
    if (rd_data[31:0] !== 32'h0) begin
      failures++; $display("FAIL reset_rd0 got=%h exp=%h", rd_data[31:0], 32'h0);
    end
    checks++;
    if (rd_data[63:32] !== 32'h0) begin
      failures++; $display("FAIL reset_rd1 got=%h exp=%h", rd_data[63:32], 32'h0);
    end
    checks++;
    if (rd_busy !== 2'b00) begin
      failures++; $display("FAIL reset_busy got=%b exp=%b", rd_busy, 2'b00);
    end
    tick();
    checks++;
    if (stall !== 1'b0) begin
      failures++; $display("FAIL reset_stall got=%b exp=0", stall);
    end
    checks++;
    if (busy_cnt !== 6'd0) begin
      failures++; $display("FAIL reset_cnt got=%0d exp=0", busy_cnt);
    end
  endtask

  task automatic test_bypass();
    we = 1'b1; wa = 5'd7; wd = 32'hDEADBEEF;
    set_reads(2'b00, 5'd7, 5'd8);
    #1;
    checks++;
    if (rd_data[31:0] !== 32'hDEADBEEF) begin
      failures++; $display("FAIL bypass_hit got=%h exp=%h", rd_data[31:0], 32'hDEADBEEF);
    end
    checks++;
    if (rd_data[63:32] !== 32'h0) begin
      failures++; $display("FAIL bypass_other_port got=%h exp=%h", rd_data[63:32], 32'h0);
    end
    tick();
    idle();
    #1;
    checks++;
    if (rd_data[31:0] !== 32'hDEADBEEF) begin
      failures++; $display("FAIL bypass_stored got=%h exp=%h", rd_data[31:0], 32'hDEADBEEF);
    end
  endtask

  task automatic test_write_readback();
    logic [ADDR_W-1:0] addrs [4];
    logic [DATA_W-1:0] vals [4];
    logic [DATA_W-1:0] exp;
    addrs = '{5'd1, 5'd2, 5'd31, 5'd15};
    vals  = '{32'h1111_0001, 32'hA5A5_5A5A, 32'hFFFF_FFFF, 32'h0BAD_F00D};
    for (int i = 0; i < 4; i++) begin
      we = 1'b1; wa = addrs[i]; wd = vals[i];
      exp_q.push_back(vals[i]);
      tick();
    end
    idle();
    for (int i = 0; i < 4; i++) begin
      set_reads(2'b00, 5'd0, addrs[i]);
      #1;
      exp = exp_q.pop_front();
      checks++;
      if (rd_data[63:32] !== exp) begin
        failures++; $display("FAIL readback_%0d got=%h exp=%h", addrs[i], rd_data[63:32], exp);
      end
    end
  endtask

  task automatic test_back_to_back();
    we = 1'b1; wa = 5'd20; wd = 32'h2020_2020;
    tick();
    wa = 5'd21; wd = 32'h2121_2121;
    set_reads(2'b00, 5'd21, 5'd20);
    #1;
    checks++;
    if (rd_data[31:0] !== 32'h2121_2121) begin
      failures++; $display("FAIL b2b_bypass got=%h exp=%h", rd_data[31:0], 32'h2121_2121);
    end
    checks++;
    if (rd_data[63:32] !== 32'h2020_2020) begin
      failures++; $display("FAIL b2b_prev got=%h exp=%h", rd_data[63:32], 32'h2020_2020);
    end
    tick();
    idle();
  endtask

  task automatic test_zero_reg();
    we = 1'b1; wa = 5'd0; wd = 32'h1234;
    set_reads(2'b00, 5'd0, 5'd0);
    #1;
    checks++;
    if (rd_data[31:0] !== 32'h0) begin
      failures++; $display("FAIL zero_bypass got=%h exp=%h", rd_data[31:0], 32'h0);
    end
    tick();
    idle();
    #1;
    checks++;
    if (rd_data[31:0] !== 32'h0) begin
      failures++; $display("FAIL zero_stored got=%h exp=%h", rd_data[31:0], 32'h0);
    end
    sb_set = 1'b1; sb_addr = 5'd0;
    tick();
    idle();
    checks++;
    if (busy_cnt !== 6'd0) begin
      failures++; $display("FAIL zero_busy_cnt got=%0d exp=0", busy_cnt);
    end
    checks++;
    if (rd_busy !== 2'b00) begin
      failures++; $display("FAIL zero_rd_busy got=%b exp=%b", rd_busy, 2'b00);
    end
  endtask

  task automatic test_hazard();
    sb_set = 1'b1; sb_addr = 5'd3;
    tick();
    idle();
    checks++;
    if (busy_cnt !== 6'd1) begin
      failures++; $display("FAIL hz_cnt_set got=%0d exp=1", busy_cnt);
    end
    set_reads(2'b10, 5'd0, 5'd3);
    #1;
    checks++;
    if (rd_busy !== 2'b10) begin
      failures++; $display("FAIL hz_rd_busy got=%b exp=%b", rd_busy, 2'b10);
    end
    tick();
    checks++;
    if (stall !== 1'b1) begin
      failures++; $display("FAIL hz_stall_set got=%b exp=1", stall);
    end
    we = 1'b1; wa = 5'd3; wd = 32'h0000_0033;
    #1;
    checks++;
    if (rd_busy !== 2'b00) begin
      failures++; $display("FAIL hz_rd_busy_clear got=%b exp=%b", rd_busy, 2'b00);
    end
    checks++;
    if (rd_data[63:32] !== 32'h0000_0033) begin
      failures++; $display("FAIL hz_bypass got=%h exp=%h", rd_data[63:32], 32'h33);
    end
    tick();
    idle();
    checks++;
    if (stall !== 1'b0) begin
      failures++; $display("FAIL hz_stall_drop got=%b exp=0", stall);
    end
    checks++;
    if (busy_cnt !== 6'd0) begin
      failures++; $display("FAIL hz_cnt_clear got=%0d exp=0", busy_cnt);
    end
    // A busy register read without rd_en shows busy but must not stall.
    sb_set = 1'b1; sb_addr = 5'd6;
    tick();
    idle();
    set_reads(2'b00, 5'd6, 5'd0);
    tick();
    checks++;
    if (stall !== 1'b0) begin
      failures++; $display("FAIL hz_no_en_stall got=%b exp=0", stall);
    end
    checks++;
    if (rd_busy !== 2'b01) begin
      failures++; $display("FAIL hz_no_en_busy got=%b exp=%b", rd_busy, 2'b01);
    end
    we = 1'b1; wa = 5'd6; wd = 32'h66;
    tick();
    idle();
  endtask

  task automatic test_set_clear_same();
    sb_set = 1'b1; sb_addr = 5'd4;
    we = 1'b1; wa = 5'd4; wd = 32'h4444_4444;
    tick();
    idle();
    set_reads(2'b00, 5'd4, 5'd0);
    #1;
    checks++;
    if (busy_cnt !== 6'd1) begin
      failures++; $display("FAIL same_cnt got=%0d exp=1", busy_cnt);
    end
    checks++;
    if (rd_busy[0] !== 1'b1) begin
      failures++; $display("FAIL same_busy got=%b exp=1", rd_busy[0]);
    end
    checks++;
    if (rd_data[31:0] !== 32'h4444_4444) begin
      failures++; $display("FAIL same_data got=%h exp=%h", rd_data[31:0], 32'h4444_4444);
    end
  endtask

  task automatic test_reset_mid();
    for (int i = 10; i < 20; i++) begin
      sb_set = 1'b1; sb_addr = ADDR_W'(i);
      tick();
    end
    idle();
    checks++;
    if (busy_cnt !== 6'd11) begin
      failures++; $display("FAIL mid_cnt got=%0d exp=11", busy_cnt);
    end
    sb_set = 1'b1; sb_addr = 5'd10;
    tick();
    idle();
    checks++;
    if (busy_cnt !== 6'd11) begin
      failures++; $display("FAIL mid_reset_dup got=%0d exp=11", busy_cnt);
    end
    set_reads(2'b11, 5'd10, 5'd4);
    tick();
    checks++;
    if (stall !== 1'b1) begin
      failures++; $display("FAIL mid_stall got=%b exp=1", stall);
    end
    // Write and scoreboard set during reset are ignored.
    reset = 1'b1;
    we = 1'b1; wa = 5'd12; wd = 32'hFFFF;
    sb_set = 1'b1; sb_addr = 5'd13;
    tick();
    reset = 1'b0;
    idle();
    checks++;
    if (busy_cnt !== 6'd0) begin
      failures++; $display("FAIL mid_cnt_reset got=%0d exp=0", busy_cnt);
    end
    checks++;
    if (stall !== 1'b0) begin
      failures++; $display("FAIL mid_stall_reset got=%b exp=0", stall);
    end
    for (int a = 0; a < 32; a++) begin
      set_reads(2'b11, ADDR_W'(a), ADDR_W'(31 - a));
      #1;
      checks++;
      if (rd_data !== 64'h0 || rd_busy !== 2'b00) begin
        failures++;
        $display("FAIL mid_clear_%0d got data=%h busy=%b exp data=0 busy=00", a, rd_data, rd_busy);
      end
    end
  endtask

  initial begin
    test_reset();
    test_bypass();
    test_write_readback();
    test_back_to_back();
    test_zero_reg();
    test_hazard();
    test_set_clear_same();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/regfile_mp_sb.md
Name: regfile_mp_sb

Overview:
- Parametrised successor to the single-write, dual-read CPU register file.
- Adds: configurable width, depth and read-port count; write-to-read bypass; a per-register busy scoreboard for long-latency producers (MDU, future cache-miss loads); a registered hazard stall output.
- Sits in ID: read ports feed operand muxes, the write port is driven from WB, and scoreboard set comes from issue logic.

Parameters:
- DATA_W, 32, register width in bits.
- ADDR_W, 5, address width; depth = 2**ADDR_W.
- NUM_RD, 2, number of read ports (1..4).
- BYPASS, 1, 1 = same-cycle write data forwarded to matching reads; 0 = reads return the stored value only.
- ZERO_REG, 1, 1 = entry 0 is hardwired to zero and never busy; 0 = entry 0 is an ordinary register.

Ports:
- clk  in  1  system clock, all state updates on rising edge.
- reset  in  1  synchronous, active-high; clears all registers and busy bits.
- rd_en  in  NUM_RD  per-port read valid; gates hazard detection only.
- rd_addr  in  NUM_RD*ADDR_W  packed read addresses; port k = bits [k*ADDR_W +: ADDR_W].
- rd_data  out  NUM_RD*DATA_W  packed read data, combinational.
- rd_busy  out  NUM_RD  per-port combinational busy flag.
- we  in  1  write enable.
- wa  in  ADDR_W  write address.
- wd  in  DATA_W  write data.
- sb_set  in  1  mark register sb_addr busy (long-latency issue).
- sb_addr  in  ADDR_W  scoreboard set address.
- stall  out  1  registered hazard flag.
- busy_cnt  out  ADDR_W+1  number of busy registers, registered.

Behaviour:
- Reset, applied on the edge where reset=1:
  - all entries = 0, all busy bits = 0, stall = 0, busy_cnt = 0.
  - we and sb_set are ignored in that cycle.
  - reset mid-operation discards all outstanding busy marks.
- Read:
  - rd_data[k] = mem[rd_addr[k]], combinational.
  - If ZERO_REG and rd_addr[k]==0: result is 0.
  - If BYPASS and we and wa==rd_addr[k] and not (ZERO_REG and wa==0): result is wd.
- Write:
  - On the edge with we=1 and not (ZERO_REG and wa==0): mem[wa] <= wd.
  - All other entries hold their value.
- Scoreboard update, per edge, evaluated in this order:
  - clear: we=1 clears busy[wa].
  - set: sb_set=1 sets busy[sb_addr].
  - Same address set and cleared in the same cycle: set wins (a new producer was issued).
  - ZERO_REG and address 0: busy[0] stays 0.
  - sb_set on an already-busy register: no change; it remains busy, single bit, no counting.
- rd_busy[k]:
  - = busy[rd_addr[k]] & ~(we & wa==rd_addr[k]) when BYPASS=1, since the bypass resolves it.
  - = busy[rd_addr[k]] when BYPASS=0.
- stall: registered OR over k of (rd_en[k] & rd_busy[k]). Valid one cycle after the addresses are presented; 0 out of reset.
- busy_cnt: registered popcount of the next-state busy vector, so it matches the busy bits after the same edge. Range 0..2**ADDR_W, or 2**ADDR_W-1 when ZERO_REG.
- No X propagation: out-of-range NUM_RD is rejected by an elaboration-time check.

Decomposition:
- Package rf_pkg:
  - RF_DATA_W / RF_ADDR_W defaults.
  - REG_ZERO constant.
  - typedef for a packed read-port bundle.
  - function popcount(busy vector).
- Sub-module rf_scoreboard: busy vector, set/clear priority, busy_cnt.
- The top level keeps the storage array, read/bypass muxing and the stall register.

Test Plan:
- Reset, then read ports 0,1 at addresses 5,9 -> rd_data=0, rd_busy=0; next cycle stall=0, busy_cnt=0.
- we=1, wa=7, wd=0xDEADBEEF, rd_addr[0]=7 in the same cycle -> rd_data[0]=0xDEADBEEF (BYPASS=1), or the old value 0 (BYPASS=0); next cycle both configurations read 0xDEADBEEF.
- Write wa=0, wd=0x1234 with ZERO_REG=1 -> reads of address 0 always return 0; sb_set on address 0 leaves busy_cnt=0.
- sb_set addr 3; next cycle rd_en[1]=1, rd_addr[1]=3 -> rd_busy[1]=1, stall=1 on the following cycle; then we wa=3 -> rd_busy clears in the same cycle, stall drops the cycle after.
- Same cycle: sb_set addr 4 and we wa=4 -> busy[4]=1 afterwards, busy_cnt increments by 1, mem[4]=wd.
- Set busy on 10 registers, assert reset mid-sequence -> next cycle busy_cnt=0, all rd_busy=0, all rd_data=0.
